// File: rtl/mult_pkg.sv
// Shared types and sizing for the signed shift-add multiplier.
package mult_pkg;

   localparam int MULT_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ARITH,
      SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/mult_control.sv
// Sequencer for the shift-add multiplier: one CLEAR, then WIDTH ARITH/SHIFT
// pairs, then DONE until Run is released.
module mult_control
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Run,
   input  logic ClearA_LoadB,
   input  logic M,
   output logic Clr_A,
   output logic Ld_B,
   output logic Add_En,
   output logic Sub,
   output logic Shift_En,
   output logic Busy,
   output logic Done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_iter;

   assign last_iter = (cnt_q == LAST);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      Clr_A    = 1'b0;
      Ld_B     = 1'b0;
      Add_En   = 1'b0;
      Sub      = 1'b0;
      Shift_En = 1'b0;
      Busy     = 1'b0;
      Done     = 1'b0;

      unique case (state_q)
         IDLE: begin
            Clr_A = ClearA_LoadB;
            Ld_B  = ClearA_LoadB;
            if (Run) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            Clr_A   = 1'b1;
            Busy    = 1'b1;
            state_d = ARITH;
         end
         ARITH: begin
            // The final iteration subtracts: the multiplier MSB carries negative weight.
            Add_En  = M;
            Sub     = last_iter & M;
            Busy    = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: begin
            Shift_En = 1'b1;
            Busy     = 1'b1;
            if (last_iter) begin
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               state_d = ARITH;
            end
         end
         DONE: begin
            Done = 1'b1;
            if (!Run) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mult_control.sv
// Randomized bench for mult_control: cycle-by-cycle output check against an
// elapsed-cycle reference, plus signed products through a modelled datapath.
module tb_mult_control;

   logic Clk = 1'b0;
   logic Reset, Run, ClearA_LoadB, M;
   logic Clr_A, Ld_B, Add_En, Sub, Shift_En, Busy, Done;

   // bench-side datapath (A, X, B and the 9-bit adder)
   logic [7:0] a_q, b_q, s_sw, b_sw;
   logic       x_q;
   logic       dp_mode, m_drv;
   logic [8:0] sum;

   int n_cmp = 0;
   int n_bad = 0;
   int phase = -1;
   logic [6:0] last_out;

   always #5 Clk = ~Clk;

   assign M = dp_mode ? b_q[0] : m_drv;

   mult_control dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
      .Clr_A(Clr_A), .Ld_B(Ld_B), .Add_En(Add_En), .Sub(Sub),
      .Shift_En(Shift_En), .Busy(Busy), .Done(Done)
   );

   assign sum = Sub ? ({a_q[7], a_q} - {s_sw[7], s_sw}) : ({a_q[7], a_q} + {s_sw[7], s_sw});

   always @(posedge Clk) begin
      if (Clr_A) begin
         a_q <= '0;
         x_q <= 1'b0;
      end
      if (Ld_B) b_q <= b_sw;
      if (Add_En) begin
         x_q <= sum[8];
         a_q <= sum[7:0];
      end
      if (Shift_En) begin
         a_q <= {x_q, a_q[7:1]};
         b_q <= {a_q[0], b_q[7:1]};
      end
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h want %h", tag, $time, got, exp);
      end
   endtask

   // Phase = cycles since Run was accepted: 1 clear, 2..17 arith/shift pairs, 18 done.
   function automatic logic [6:0] model_out(int ph, logic cla, logic m);
      logic clr, ld, add, sub, sh, busy, dn;
      {clr, ld, add, sub, sh, busy, dn} = '0;
      if (ph == 0) begin
         clr = cla;
         ld  = cla;
      end else if (ph == 1) begin
         clr  = 1'b1;
         busy = 1'b1;
      end else if (ph <= 17) begin
         busy = 1'b1;
         if (ph % 2 == 0) begin
            add = m;
            sub = m && (ph == 16);
         end else begin
            sh = 1'b1;
         end
      end else begin
         dn = 1'b1;
      end
      return {clr, ld, add, sub, sh, busy, dn};
   endfunction

   task automatic tick(input logic r, input logic c, input logic rs, input logic m);
      logic [6:0] exp;
      Run = r; ClearA_LoadB = c; Reset = rs; m_drv = m;
      @(negedge Clk);
      last_out = {Clr_A, Ld_B, Add_En, Sub, Shift_En, Busy, Done};
      if (phase >= 0) begin
         exp = model_out(phase, c, M);
         chk("ctl", 16'(last_out), 16'(exp));
      end
      if (rs)               phase = 0;
      else if (phase == 0)  phase = r ? 1 : 0;
      else if (phase == 18) phase = r ? 18 : 0;
      else if (phase > 0)   phase = phase + 1;
      @(posedge Clk);
      #1;
   endtask

   task automatic run_mult(input logic [7:0] s, input logic [7:0] b);
      int sv, bv;
      logic [15:0] p;
      sv = $signed(s);
      bv = $signed(b);
      p  = 16'(sv * bv);
      s_sw = s; b_sw = b; dp_mode = 1'b1;
      tick(0, 1, 0, 0);
      tick(1, 0, 0, 0);
      for (int i = 0; i < 40 && !last_out[0]; i++) tick(0, 0, 0, 0);
      chk("mul_done", 16'(last_out[0]), 16'd1);
      chk("product", {a_q, b_q}, p);
      dp_mode = 1'b0;
   endtask

   initial begin
      Run = 0; ClearA_LoadB = 0; Reset = 1; m_drv = 0; dp_mode = 0;
      s_sw = 0; b_sw = 0; a_q = 0; b_q = 0; x_q = 0;
      last_out = '0;
      @(posedge Clk); #1;
      tick(0, 0, 1, 0);
      tick(0, 0, 0, 0);

      // M=0, Run held 20 cycles, then held through DONE, then release and restart
      for (int i = 0; i < 30; i++) tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
      tick(1, 0, 0, 1);
      for (int i = 0; i < 19; i++) tick(0, 0, 0, 1);
      tick(0, 0, 0, 0);

      // reset mid-run, then a full clean run
      tick(1, 0, 0, 1);
      for (int i = 0; i < 6; i++) tick(0, 0, 0, 1);
      tick(0, 0, 1, 1);
      tick(0, 0, 0, 0);
      tick(1, 0, 0, 0);
      for (int i = 0; i < 19; i++) tick(0, 1, 0, 0);

      // ClearA_LoadB in IDLE, with and without Run
      tick(0, 1, 0, 0);
      tick(1, 1, 0, 0);
      for (int i = 0; i < 20; i++) tick(0, 0, 0, 0);

      run_mult(8'hFD, 8'h07);
      run_mult(8'h80, 8'h80);
      run_mult(8'h7F, 8'h80);
      run_mult(8'h00, 8'hFF);
      for (int i = 0; i < 12; i++) run_mult(8'($urandom), 8'($urandom));

      for (int i = 0; i < 600; i++)
         tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 60) == 0), 1'($urandom_range(0, 1)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mult_control.md
# mult_control

Control unit for the 8-bit signed shift-add multiplier. It sequences the datapath registers (A, B, X) and the 9-bit adder/subtractor: it issues clear, load, add, subtract and shift strobes over 8 iterations per Run. It sits directly upstream of the 16-bit/8-bit registers and drives their load and shift enables. The LSB of B (M) is fed back so the unit can decide whether each iteration adds.

## Interface
- WIDTH, 8, multiplier width; number of add/shift iterations per run

- Clk  in  1  system clock; all state changes on posedge
- Reset  in  1  synchronous, active-high; forces IDLE on next posedge
- Run  in  1  level; start request, must return low between runs
- ClearA_LoadB  in  1  level; in IDLE clears A/X and loads B from switches
- M  in  1  current LSB of register B
- Clr_A  out  1  clear A and X this cycle
- Ld_B  out  1  load B from switches this cycle
- Add_En  out  1  load A,X with adder result this cycle
- Sub  out  1  adder selects A − S (valid only with Add_En)
- Shift_En  out  1  arithmetic right shift of X:A:B this cycle
- Busy  out  1  run in progress (CLEAR/ARITH/SHIFT)
- Done  out  1  run finished, result valid in A:B

Clock and reset: one clock, Clk. Reset is synchronous and active-high.

## Operation
- States: IDLE, CLEAR, ARITH, SHIFT, DONE; iteration counter cnt, $clog2(WIDTH) bits.
- Reset: state=IDLE, cnt=0. In IDLE, all outputs are 0 unless ClearA_LoadB=1.
- IDLE:
  - Clr_A = Ld_B = ClearA_LoadB (combinational).
  - Run=1 → CLEAR, cnt=0. Run wins if both inputs are high; Clr_A/Ld_B still assert that cycle.
- CLEAR: Clr_A=1 → ARITH.
- ARITH:
  - Add_En=M; Sub=(cnt==WIDTH−1)&M → SHIFT.
  - Last-iteration subtract implements the two's-complement sign weight.
- SHIFT: Shift_En=1.
  - If cnt==WIDTH−1 → DONE, cnt held.
  - Otherwise cnt+1 → ARITH.
- DONE: Done=1.
  - Run=0 → IDLE.
  - Run=1 → stay. No auto-restart.
- ClearA_LoadB is ignored in every state except IDLE.
- Outputs are Moore (decoded from state and cnt), except Add_En/Sub (depend on M) and the IDLE Clr_A/Ld_B gating.
- At most one of Clr_A, Add_En, Shift_En is high in any cycle outside IDLE.

## Timing
- Run sampled high at posedge k in IDLE:
  - CLEAR during cycle k+1.
  - ARITH/SHIFT pairs occupy cycles k+2…k+1+2·WIDTH.
  - DONE from cycle k+2+2·WIDTH (k+18 for WIDTH=8).
- Busy is high for exactly 1+2·WIDTH cycles (17).
- M is sampled combinationally in ARITH. It reflects B after the previous SHIFT; the datapath must present it the same cycle.
- Reset asserted in any state: IDLE and cnt=0 after that posedge; all strobes low the following cycle. Datapath contents are not restored.
- Run dropping mid-run has no effect; the run completes.

## Structure
- Package mult_pkg:
  - state_t enum {IDLE, CLEAR, ARITH, SHIFT, DONE}
  - localparam MULT_WIDTH=8
- Single module with two processes:
  - always_ff for state/cnt.
  - always_comb for next-state and outputs, with defaults assigned at the top.
- No sub-module; the counter is inline. Datapath (reg_16-class registers, adder) lives in the parent top.

## Test plan
- M held 0, Run pulsed high at cycle 0, held 20 cycles → Clr_A at cycle 1; 8 Shift_En pulses on cycles 3,5,…,17; Add_En never; Done from cycle 18; Busy cycles 1–17.
- M held 1, Run high → Add_En on cycles 2,4,…,16; Sub only on cycle 16; Done at 18.
- Run held high through DONE for 10 cycles → Done stays 1, no Clr_A. Run low → IDLE next cycle. Run high again → new CLEAR.
- Reset asserted at cycle 7 of a run → IDLE at the next edge; all outputs 0; Busy 0; next Run restarts with cnt=0 (8 full shifts).
- ClearA_LoadB=1 in IDLE → Clr_A=Ld_B=1 same cycle. ClearA_LoadB=1 during ARITH → Ld_B stays 0.
- Integrated with datapath, S=0xFD (−3), B=0x07 → A:B=0xFFEB (−21) at Done. S=0x80, B=0x80 → 0x4000.
